sin_pout_bank: RTL and testbench



---
 rtl/sin_pout_pkg.sv | 30 +++
 rtl/sin_pout_bank_if.sv | 39 +++
 rtl/sin_pout_bank_shifter.sv | 74 +++++++
 rtl/sin_pout_bank.sv | 86 ++++++++
 tb/tb_sin_pout_bank.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sin_pout_pkg.sv
// sin_pout_pkg: shared constants and helpers for the sin_pout_bank receiver.
//   clog2      - ceiling log2, usable in constant expressions
//   chan_w     - channel-index width, never below 1
//   PARITY_BITS/FRAME_LEN - frame length for the default width; grows by one
//                when SIN_POUT_PARITY_EN is defined (trailing odd-parity bit)
package sin_pout_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;

`ifdef SIN_POUT_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam int FRAME_LEN = DEF_WIDTH + PARITY_BITS;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int chan_w(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

endpackage

// File: rtl/sin_pout_bank_if.sv
// sin_pout_if: host-side bus of the serial-in / parallel-out bank.
//   select    qualifies din/le; low means hold everything
//   le        latch strobe (no shift in a cycle where it is sampled)
//   chan      destination channel for le
//   din       serial data
//   dout      all channel registers, channel k at dout[k*WIDTH +: WIDTH]
//   strobe    one-cycle pulse on the channel just committed
//   frame_err result of the most recent latch attempt (1 = rejected)
//   count     bits shifted since the last latch attempt, saturating
// Modports: master = host, slave = sin_pout_bank.
interface sin_pout_if
    import sin_pout_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
);
    localparam int CHAN_W = chan_w(CHANNELS);
    localparam int CNT_W  = clog2(WIDTH + 2);

    logic                        select;
    logic                        le;
    logic [CHAN_W-1:0]           chan;
    logic                        din;
    logic [0:CHANNELS*WIDTH-1]   dout;
    logic [0:CHANNELS-1]         strobe;
    logic                        frame_err;
    logic [CNT_W-1:0]            count;

    modport master (
        output select, le, chan, din,
        input  dout, strobe, frame_err, count
    );

    modport slave (
        input  select, le, chan, din,
        output dout, strobe, frame_err, count
    );

endinterface

// File: rtl/sin_pout_bank_shifter.sv
// sin_pout_shifter: serial shift register with saturating bit counter.
//   shift_en  shift din in this cycle (select & ~le)
//   clear     latch attempt this cycle: zero the counter (and parity),
//             keep the shift register contents
//   data      WIDTH data bits, bit i of the channel value at data[i]
//   count     bits shifted since the last clear, saturating at all-ones
//   frame_ok  the bits shifted so far form exactly one valid frame
// With SIN_POUT_PARITY_EN the register is one bit wider and the last bit
// shifted is an odd-parity bit, dropped from data.
module sin_pout_shifter
    import sin_pout_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_en,
    input  logic               clear,
    input  logic               din,
    output logic [0:WIDTH-1]   data,
    output logic [CNT_W-1:0]   count,
    output logic               frame_ok
);
    localparam int SH_W = WIDTH + PARITY_BITS;
    // LSB-first with parity leaves the parity bit at index 0, data above it.
    localparam int DATA_OFF = (PARITY_BITS != 0 && MSB_FIRST == 0) ? 1 : 0;

    logic [0:SH_W-1] sh, sh_next;

    // MSB_FIRST=1 moves bits toward index 0 so the first bit ends at bit 0;
    // MSB_FIRST=0 moves them toward SH_W-1.
    always_comb begin
        sh_next = sh;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < SH_W - 1; i++) sh_next[i] = sh[i+1];
            sh_next[SH_W-1] = din;
        end else begin
            for (int i = 1; i < SH_W; i++) sh_next[i] = sh[i-1];
            sh_next[0] = din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh    <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (shift_en) begin
            sh <= sh_next;
            if (count != '1) count <= count + 1'b1;
        end
    end

    assign data = sh[DATA_OFF +: WIDTH];

`ifdef SIN_POUT_PARITY_EN
    // Running XOR of the bits shifted since the last latch attempt; with the
    // count exactly SH_W these are precisely the register contents.
    logic par;

    always_ff @(posedge clk) begin
        if (reset || clear) par <= 1'b0;
        else if (shift_en)  par <= par ^ din;
    end

    assign frame_ok = (count == CNT_W'(SH_W)) && par;
`else
    assign frame_ok = (count == CNT_W'(SH_W));
`endif

endmodule

// File: rtl/sin_pout_bank.sv
// sin_pout_bank: serial-in, parallel-out receiver with CHANNELS latched
// output registers.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   bus         sin_pout_if slave: select/le/chan/din in; dout/strobe/
//               frame_err/count out
// A latch attempt (select & le) commits the shift register into channel
// chan only when exactly one frame has been shifted and chan exists;
// otherwise frame_err is raised. dout, strobe and frame_err are registered.
// Optional feature: define SIN_POUT_PARITY_EN for a trailing odd-parity bit.
module sin_pout_bank
    import sin_pout_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset,
    sin_pout_if.slave    bus
);
    localparam int CHAN_W = chan_w(CHANNELS);
    localparam int CNT_W  = clog2(WIDTH + 2);

    logic                latch_try;
    logic                chan_ok;
    logic                accept;
    logic                frame_ok;
    logic [0:WIDTH-1]    data;
    logic [0:CHANNELS-1] hit;
    logic [0:CHANNELS-1] strobe_q;
    logic                frame_err_q;

    assign latch_try = bus.select & bus.le;
    assign chan_ok   = (32'(bus.chan) < CHANNELS);
    assign accept    = latch_try & frame_ok & chan_ok;

    sin_pout_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .shift_en (bus.select & ~bus.le),
        .clear    (latch_try),
        .din      (bus.din),
        .data     (data),
        .count    (bus.count),
        .frame_ok (frame_ok)
    );

    // One-hot channel decode; doubles as the per-channel latch enable and
    // the next strobe value.
    always_comb begin
        hit = '0;
        for (int k = 0; k < CHANNELS; k++)
            hit[k] = accept && (bus.chan == CHAN_W'(k));
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [0:WIDTH-1] lat;

        always_ff @(posedge clk) begin
            if (reset)       lat <= '0;
            else if (hit[k]) lat <= data;
        end

        assign bus.dout[k*WIDTH +: WIDTH] = lat;
    end

    // strobe is rebuilt every cycle so it falls after one cycle, including
    // when select drops; frame_err only moves on a latch attempt.
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            strobe_q <= hit;
            if (latch_try) frame_err_q <= ~accept;
        end
    end

    assign bus.strobe    = strobe_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_sin_pout_bank.sv
module tb_sin_pout_bank;

`ifdef SIN_POUT_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic clk = 1'b0;
    logic rst0, rst1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    // DUT0: MSB_FIRST=1, 4 channels. DUT1: MSB_FIRST=0, 3 channels so that
    // chan=3 is out of range.
    sin_pout_if #(.WIDTH(8), .CHANNELS(4)) bus0 ();
    sin_pout_if #(.WIDTH(8), .CHANNELS(3)) bus1 ();

    sin_pout_bank #(.WIDTH(8), .CHANNELS(4), .MSB_FIRST(1)) u0 (
        .clk(clk), .reset(rst0), .bus(bus0)
    );
    sin_pout_bank #(.WIDTH(8), .CHANNELS(3), .MSB_FIRST(0)) u1 (
        .clk(clk), .reset(rst1), .bus(bus1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Channel k as a value with bit i = dout[k*8+i].
    function automatic logic [7:0] chv(input int w, input int k);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            if (w == 0) v[i] = bus0.dout[k*8+i];
            else        v[i] = bus1.dout[k*8+i];
        end
        return v;
    endfunction

    // One clock on DUT w; the other DUT sees select=0.
    task automatic step(input int w, input logic s, input logic l,
                        input logic [1:0] c, input logic d);
        bus0.select = 1'b0;
        bus1.select = 1'b0;
        if (w == 0) begin
            bus0.select = s; bus0.le = l; bus0.chan = c; bus0.din = d;
        end else begin
            bus1.select = s; bus1.le = l; bus1.chan = c; bus1.din = d;
        end
        @(posedge clk); #1;
    endtask

    // Send positions lo..hi of value v in wire order (DUT0 bit 0 first,
    // DUT1 bit 7 first).
    task automatic shift_range(input int w, input logic [7:0] v, input int lo, input int hi);
        for (int p = lo; p <= hi; p++)
            step(w, 1'b1, 1'b0, 2'd0, (w == 0) ? v[p] : v[7-p]);
    endtask

    task automatic shift_frame(input int w, input logic [7:0] v);
        shift_range(w, v, 0, 7);
`ifdef SIN_POUT_PARITY_EN
        step(w, 1'b1, 1'b0, 2'd0, ~^v);
`endif
    endtask

    task automatic latch(input int w, input logic [1:0] c);
        step(w, 1'b1, 1'b1, c, 1'b0);
    endtask

    initial begin
        // Reset held 2 cycles with select=1, din=1.
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.select = 1'b1; bus0.le = 1'b0; bus0.chan = 2'd0; bus0.din = 1'b1;
        bus1.select = 1'b1; bus1.le = 1'b0; bus1.chan = 2'd0; bus1.din = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout0",  32'(bus0.dout), 32'h0);
        check("rst_strobe0", 32'(bus0.strobe), 32'h0);
        check("rst_err0",   32'(bus0.frame_err), 32'h0);
        check("rst_count0", 32'(bus0.count), 32'h0);
        check("rst_dout1",  32'(bus1.dout), 32'h0);
        check("rst_count1", 32'(bus1.count), 32'h0);
        rst0 = 1'b0; rst1 = 1'b0;

        // A5 into channel 2 (bit 0 shifted first).
        shift_frame(0, 8'hA5);
        check("a5_count", 32'(bus0.count), 32'(FL));
        latch(0, 2'd2);
        check("a5_ch2", 32'(chv(0, 2)), 32'hA5);
        check("a5_strobe", 32'(bus0.strobe), 32'(4'b0010));
        check("a5_ch0", 32'(chv(0, 0)), 32'h0);
        check("a5_ch1", 32'(chv(0, 1)), 32'h0);
        check("a5_ch3", 32'(chv(0, 3)), 32'h0);
        check("a5_err", 32'(bus0.frame_err), 32'h0);
        check("a5_cnt_clr", 32'(bus0.count), 32'h0);
        step(0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("strobe_fall", 32'(bus0.strobe), 32'h0);

        // Short frame (7 bits).
        shift_range(0, 8'hFF, 0, 6);
        check("short_count", 32'(bus0.count), 32'd7);
        latch(0, 2'd0);
        check("short_err", 32'(bus0.frame_err), 32'h1);
        check("short_strobe", 32'(bus0.strobe), 32'h0);
        check("short_ch0", 32'(chv(0, 0)), 32'h0);
        check("short_count0", 32'(bus0.count), 32'h0);

        // Long frame (12 bits).
        for (int i = 0; i < 12; i++) step(0, 1'b1, 1'b0, 2'd0, 1'b1);
        check("long_count", 32'(bus0.count), 32'd12);
        latch(0, 2'd1);
        check("long_err", 32'(bus0.frame_err), 32'h1);
        check("long_ch1", 32'(chv(0, 1)), 32'h0);
        check("long_ch2", 32'(chv(0, 2)), 32'hA5);

        // Good frame then an immediate second latch (sees count 0).
        shift_frame(0, 8'h3C);
        latch(0, 2'd0);
        check("3c_ch0", 32'(chv(0, 0)), 32'h3C);
        check("3c_err", 32'(bus0.frame_err), 32'h0);
        check("3c_strobe", 32'(bus0.strobe), 32'(4'b1000));
        latch(0, 2'd0);
        check("b2b_err", 32'(bus0.frame_err), 32'h1);
        check("b2b_strobe", 32'(bus0.strobe), 32'h0);
        check("b2b_ch0", 32'(chv(0, 0)), 32'h3C);

        // Hold with select=0 mid-frame while din/le toggle.
        shift_range(0, 8'h5A, 0, 3);
        check("hold_pre", 32'(bus0.count), 32'd4);
        for (int i = 0; i < 20; i++) step(0, 1'b0, i[0], 2'd3, ~i[0]);
        check("hold_count", 32'(bus0.count), 32'd4);
        check("hold_ch3", 32'(chv(0, 3)), 32'h0);
        check("hold_err", 32'(bus0.frame_err), 32'h1);
        shift_range(0, 8'h5A, 4, 7);
`ifdef SIN_POUT_PARITY_EN
        step(0, 1'b1, 1'b0, 2'd0, ~^8'h5A);
`endif
        latch(0, 2'd3);
        check("hold_done_ch3", 32'(chv(0, 3)), 32'h5A);
        check("hold_done_strobe", 32'(bus0.strobe), 32'(4'b0001));
        check("hold_done_err", 32'(bus0.frame_err), 32'h0);

        // Counter saturates at 15.
        for (int i = 0; i < 20; i++) step(0, 1'b1, 1'b0, 2'd0, 1'b0);
        check("sat_count", 32'(bus0.count), 32'd15);
        latch(0, 2'd1);
        check("sat_err", 32'(bus0.frame_err), 32'h1);

`ifdef SIN_POUT_PARITY_EN
        // Wrong parity bit is rejected.
        shift_range(0, 8'hA5, 0, 7);
        step(0, 1'b1, 1'b0, 2'd0, 1'b0);
        latch(0, 2'd1);
        check("par_bad_err", 32'(bus0.frame_err), 32'h1);
        check("par_bad_ch1", 32'(chv(0, 1)), 32'h0);
`endif

        // DUT1, first bit lands in bit 7.
        shift_frame(1, 8'h80);
        latch(1, 2'd1);
        check("lsb_ch1", 32'(chv(1, 1)), 32'h80);
        check("lsb_strobe", 32'(bus1.strobe), 32'(3'b010));
        check("lsb_err", 32'(bus1.frame_err), 32'h0);

        // Reset after 4 bits discards them; next frame is accepted.
        shift_range(1, 8'hFF, 0, 3);
        check("mid_count", 32'(bus1.count), 32'd4);
        rst1 = 1'b1;
        step(1, 1'b1, 1'b1, 2'd0, 1'b1);
        rst1 = 1'b0;
        check("mid_rst_count", 32'(bus1.count), 32'h0);
        check("mid_rst_ch1", 32'(chv(1, 1)), 32'h0);
        shift_frame(1, 8'h3C);
        latch(1, 2'd0);
        check("lsb_3c_ch0", 32'(chv(1, 0)), 32'h3C);
        check("lsb_3c_err", 32'(bus1.frame_err), 32'h0);
        check("lsb_3c_strobe", 32'(bus1.strobe), 32'(3'b100));

        // Out-of-range channel.
        shift_frame(1, 8'h11);
        latch(1, 2'd3);
        check("oor_err", 32'(bus1.frame_err), 32'h1);
        check("oor_strobe", 32'(bus1.strobe), 32'h0);
        check("oor_ch0", 32'(chv(1, 0)), 32'h3C);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
